rompack_port_arbiter: RTL

// - Owns the single-port ROM-pack RAM. Shares it between the HPS ioctl download ("Load to ROM Pack", F1) and CPU reads arriving via the ROM-module PIO.
// - Sits between hps_io ioctl signals and the ROM-pack RAM inside the PMD85 core. CPU reads always win; download bytes are buffered in a small FIFO.
// - Tracks loaded size and a loading indicator that drives LED_YELLOW.

---
 rtl/rompack_port_arbiter.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/rompack_port_arbiter.sv
// Single-port ROM-pack RAM arbiter: CPU reads preempt buffered ioctl download writes.
// Define ROMPACK_FILL_EN to pad memory above loaded_size with 8'hFF after each download.
module rompack_port_arbiter #(
    parameter int unsigned ADDR_W  = 15,
    parameter int unsigned FIFO_D  = 4,
    parameter int unsigned RD_LAT  = 1,
    parameter int unsigned ROM_IDX = 1
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic              cpu_rd_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [7:0]        cpu_rd_data,
    output logic              cpu_rd_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_dout,
    output logic              loading,
    output logic [ADDR_W:0]   loaded_size,
    output logic              overflow
);

    localparam int unsigned PTR_W = $clog2(FIFO_D);
    localparam logic [ADDR_W:0] FULL_SIZE = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StRdWait,
        StWrite
`ifdef ROMPACK_FILL_EN
        , StClear
`endif
    } state_e;

    state_e            state_q, state_d;
    logic              active, active_q, dl_rise;
    logic [ADDR_W-1:0] fifo_addr_q [FIFO_D];
    logic [7:0]        fifo_data_q [FIFO_D];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]    count_q;
    logic              fifo_empty, fifo_full, addr_hi, push, drop, pop;
    logic [ADDR_W:0]   push_size, loaded_q, loaded_d;
    logic              ovf_q, ovf_d;
    logic              rd_pend_q, dispatch, capture;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [1:0]        wait_q, wait_d;
    logic              fill_work;

    assign active     = ioctl_download && (ioctl_index == 8'(ROM_IDX));
    assign dl_rise    = active && !active_q;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (PTR_W+1)'(FIFO_D));
    assign addr_hi    = (ioctl_addr[24:ADDR_W] != '0);
    assign push       = active && ioctl_wr && !addr_hi && !fifo_full;
    assign drop       = active && ioctl_wr && (addr_hi || fifo_full);
    assign push_size  = {1'b0, ioctl_addr[ADDR_W-1:0]} + (ADDR_W+1)'(1);

    assign loading     = active_q || !fifo_empty || fill_work;
    assign loaded_size = loaded_q;
    assign overflow    = ovf_q;

    always_comb begin
        loaded_d = dl_rise ? '0 : loaded_q;
        if (push && (push_size > loaded_d)) loaded_d = push_size;
        ovf_d = dl_rise ? 1'b0 : ovf_q;
        if (drop) ovf_d = 1'b1;
    end

`ifdef ROMPACK_FILL_EN
    logic            fill_on_q, dl_fall, fill_step;
    logic [ADDR_W:0] fill_addr_q;

    assign dl_fall   = !active && active_q;
    assign fill_work = fill_on_q;

    // Fill starts from the final loaded_size; IDLE priority lets the FIFO drain first.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            fill_on_q   <= 1'b0;
            fill_addr_q <= '0;
        end else if (dl_rise) begin
            fill_on_q <= 1'b0;
        end else if (dl_fall && (loaded_q != FULL_SIZE)) begin
            fill_on_q   <= 1'b1;
            fill_addr_q <= loaded_q;
        end else if (fill_step) begin
            fill_addr_q <= fill_addr_q + (ADDR_W+1)'(1);
            if (fill_addr_q + (ADDR_W+1)'(1) == FULL_SIZE) fill_on_q <= 1'b0;
        end
    end
`else
    assign fill_work = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        mem_addr = '0;
        mem_din  = '0;
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        pop      = 1'b0;
        dispatch = 1'b0;
        capture  = 1'b0;
`ifdef ROMPACK_FILL_EN
        fill_step = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                // The live request is honoured directly so mem_re follows it by one cycle.
                if (rd_pend_q || cpu_rd_req) begin
                    state_d  = StRead;
                    dispatch = 1'b1;
                end else if (!fifo_empty) begin
                    state_d = StWrite;
`ifdef ROMPACK_FILL_EN
                end else if (fill_on_q) begin
                    state_d = StClear;
`endif
                end
            end
            StRead: begin
                mem_re   = 1'b1;
                mem_addr = rd_addr_q;
                wait_d   = 2'(RD_LAT - 1);
                state_d  = StRdWait;
            end
            StRdWait: begin
                if (wait_q == 2'd0) begin
                    capture = 1'b1;
                    state_d = StIdle;
                end else begin
                    wait_d = wait_q - 2'd1;
                end
            end
            StWrite: begin
                mem_we   = 1'b1;
                mem_addr = fifo_addr_q[rd_ptr_q];
                mem_din  = fifo_data_q[rd_ptr_q];
                pop      = 1'b1;
                state_d  = StIdle;
            end
`ifdef ROMPACK_FILL_EN
            StClear: begin
                mem_we    = 1'b1;
                mem_addr  = fill_addr_q[ADDR_W-1:0];
                mem_din   = 8'hFF;
                fill_step = 1'b1;
                state_d   = StIdle;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= ioctl_addr[ADDR_W-1:0];
            fifo_data_q[wr_ptr_q] <= ioctl_dout;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= StIdle;
            active_q     <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            loaded_q     <= '0;
            ovf_q        <= 1'b0;
            rd_pend_q    <= 1'b0;
            rd_addr_q    <= '0;
            wait_q       <= '0;
            cpu_rd_valid <= 1'b0;
            cpu_rd_data  <= '0;
        end else begin
            state_q  <= state_d;
            active_q <= active;
            loaded_q <= loaded_d;
            ovf_q    <= ovf_d;
            wait_q   <= wait_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
            // Latest request wins; the address is consumed by the single READ cycle.
            if (cpu_rd_req) rd_addr_q <= cpu_addr;
            rd_pend_q    <= (rd_pend_q || cpu_rd_req) && !dispatch;
            cpu_rd_valid <= capture;
            if (capture) cpu_rd_data <= mem_dout;
        end
    end

endmodule
